cordic_bus_regs: RTL and testbench

- Memory-mapped register block on the CPU side of the CORDIC accelerator. It is the bus-facing end of the controller's bus port.
- Holds the X/Y/Z operands and the control word presented to the controller. It captures the status write-backs and results the controller returns.
- Turns the controller's one-cycle interrupt pulse into a sticky, software-clearable IRQ.
- A run-tracking FSM protects operands while a computation is in flight.

---
 rtl/cordic_bus_regs.sv | 173 +++++++++++++++++
 tb/tb_cordic_bus_regs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_bus_regs.sv
// CPU-facing register block for the CORDIC controller: operand/control registers, result
// capture, sticky IRQ and a run-tracking FSM that locks operands during a computation.
module cordic_bus_regs #(
    parameter int unsigned p_WIDTH      = 32,
    parameter int unsigned p_HALFWORD   = 16,
    parameter int unsigned p_ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_sel,
    input  logic                    bus_write,
    input  logic [p_ADDR_WIDTH-1:0] bus_addr,
    input  logic [p_WIDTH-1:0]      bus_wdata,
    output logic [p_WIDTH-1:0]      bus_rdata,
    output logic                    bus_ready,
    output logic                    bus_err,
    output logic [p_WIDTH-1:0]      ctrl_reg_in,
    output logic [p_WIDTH-1:0]      x_in,
    output logic [p_WIDTH-1:0]      y_in,
    output logic [p_WIDTH-1:0]      z_in,
    input  logic [p_WIDTH-1:0]      ctrl_reg_out,
    input  logic                    ctrl_reg_we,
    input  logic [p_WIDTH-1:0]      x_result,
    input  logic [p_WIDTH-1:0]      y_result,
    input  logic [p_WIDTH-1:0]      z_result,
    input  logic                    cordic_int,
    output logic                    irq
);

    localparam int unsigned StatusW = p_WIDTH - p_HALFWORD;

    localparam logic [p_ADDR_WIDTH-1:0] AddrCtrl = p_ADDR_WIDTH'(5'h00);
    localparam logic [p_ADDR_WIDTH-1:0] AddrX    = p_ADDR_WIDTH'(5'h04);
    localparam logic [p_ADDR_WIDTH-1:0] AddrY    = p_ADDR_WIDTH'(5'h08);
    localparam logic [p_ADDR_WIDTH-1:0] AddrZ    = p_ADDR_WIDTH'(5'h0C);
    localparam logic [p_ADDR_WIDTH-1:0] AddrIrq  = p_ADDR_WIDTH'(5'h10);

    localparam logic [p_HALFWORD-1:0] ShadowRst = p_HALFWORD'(16'h1FF0);
    localparam logic [StatusW-1:0]    StatusRst = StatusW'(1);

    typedef enum logic [1:0] {StIdle, StLaunch, StBusy} state_e;

    state_e stateQ, stateD;
    logic [p_HALFWORD-1:0] shadowQ, shadowD;
    logic [StatusW-1:0]    statusQ, statusD;
    logic [p_WIDTH-1:0]    xInQ, xInD, yInQ, yInD, zInQ, zInD;
    logic [p_WIDTH-1:0]    xResQ, xResD, yResQ, yResD, zResQ, zResD;
    logic                  pendingQ, pendingD;
    logic [p_WIDTH-1:0]    rdataQ, rdataD;
    logic                  readyQ, readyD, errQ, errD;

    logic accept, addrErr, ctrlWr;
    logic unusedBits;

    // Controller only ever returns flags in the upper half.
    assign unusedBits = ^ctrl_reg_out[p_HALFWORD-1:0];

    assign accept  = bus_sel && !readyQ;
    assign addrErr = (bus_addr[1:0] != 2'b00) || (bus_addr > AddrIrq);
    assign ctrlWr  = accept && bus_write && !addrErr && (bus_addr == AddrCtrl);

    always_comb begin
        stateD   = stateQ;
        shadowD  = shadowQ;
        statusD  = statusQ;
        xInD     = xInQ;
        yInD     = yInQ;
        zInD     = zInQ;
        xResD    = xResQ;
        yResD    = yResQ;
        zResD    = zResQ;
        pendingD = pendingQ;
        rdataD   = '0;
        errD     = 1'b0;
        readyD   = accept;

        if (accept) begin
            if (addrErr) begin
                errD = 1'b1;
            end else if (!bus_write) begin
                case (bus_addr)
                    AddrCtrl: rdataD = {statusQ, shadowQ};
                    AddrX:    rdataD = xResQ;
                    AddrY:    rdataD = yResQ;
                    AddrZ:    rdataD = zResQ;
                    AddrIrq:  rdataD = {{(p_WIDTH-1){1'b0}}, pendingQ};
                    default:  rdataD = '0;
                endcase
            end else begin
                case (bus_addr)
                    AddrCtrl: begin
                        if (stateQ == StIdle) begin
                            shadowD = bus_wdata[p_HALFWORD-1:0];
                            if (bus_wdata[0]) stateD = StLaunch;
                        end else begin
                            shadowD[1] = bus_wdata[1];
                        end
                    end
                    AddrX:   if (stateQ == StIdle) xInD = bus_wdata; else errD = 1'b1;
                    AddrY:   if (stateQ == StIdle) yInD = bus_wdata; else errD = 1'b1;
                    AddrZ:   if (stateQ == StIdle) zInD = bus_wdata; else errD = 1'b1;
                    AddrIrq: if (bus_wdata[0]) pendingD = 1'b0;
                    default: errD = 1'b1;
                endcase
            end
        end

        if (ctrl_reg_we) begin
            statusD = ctrl_reg_out[p_WIDTH-1:p_HALFWORD];
            unique case (stateQ)
                StLaunch: begin
                    shadowD[0] = 1'b0;
                    stateD     = StBusy;
                end
                StBusy: begin
                    if (ctrl_reg_out[p_HALFWORD]) begin
                        xResD  = x_result;
                        yResD  = y_result;
                        zResD  = z_result;
                        stateD = StIdle;
                        // A simultaneous CPU write owns the stop bit.
                        if (!ctrlWr) shadowD[1] = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (cordic_int) pendingD = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StIdle;
            shadowQ  <= ShadowRst;
            statusQ  <= StatusRst;
            xInQ     <= '0;
            yInQ     <= '0;
            zInQ     <= '0;
            xResQ    <= '0;
            yResQ    <= '0;
            zResQ    <= '0;
            pendingQ <= 1'b0;
            rdataQ   <= '0;
            readyQ   <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            shadowQ  <= shadowD;
            statusQ  <= statusD;
            xInQ     <= xInD;
            yInQ     <= yInD;
            zInQ     <= zInD;
            xResQ    <= xResD;
            yResQ    <= yResD;
            zResQ    <= zResD;
            pendingQ <= pendingD;
            rdataQ   <= rdataD;
            readyQ   <= readyD;
            errQ     <= errD;
        end
    end

    assign bus_rdata   = rdataQ;
    assign bus_ready   = readyQ;
    assign bus_err     = errQ;
    assign ctrl_reg_in = {{StatusW{1'b0}}, shadowQ};
    assign x_in        = xInQ;
    assign y_in        = yInQ;
    assign z_in        = zInQ;
    assign irq         = pendingQ;

endmodule

// File: tb/tb_cordic_bus_regs.sv
// Directed bench for cordic_bus_regs: bus responses go through a scoreboard queue checked by a
// monitor on bus_ready; sideband outputs are checked inline.
module tb_cordic_bus_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_sel, bus_write;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready, bus_err;
    logic [31:0] ctrl_reg_in, x_in, y_in, z_in;
    logic [31:0] ctrl_reg_out, x_result, y_result, z_result;
    logic        ctrl_reg_we, cordic_int, irq;

    int total = 0;
    int bad   = 0;
    logic [32:0] sbq[$];

    cordic_bus_regs dut (
        .clk          (clk),
        .rst          (rst),
        .bus_sel      (bus_sel),
        .bus_write    (bus_write),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready    (bus_ready),
        .bus_err      (bus_err),
        .ctrl_reg_in  (ctrl_reg_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .ctrl_reg_out (ctrl_reg_out),
        .ctrl_reg_we  (ctrl_reg_we),
        .x_result     (x_result),
        .y_result     (y_result),
        .z_result     (z_result),
        .cordic_int   (cordic_int),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every bus_ready beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus_ready) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: got rdata=%h err=%b expected no response",
                         bus_rdata, bus_err);
            end else begin
                logic [32:0] e;
                e = sbq.pop_front();
                if ({bus_err, bus_rdata} !== e) begin
                    bad++;
                    $display("FAIL bus_resp: got err=%b rdata=%h expected err=%b rdata=%h",
                             bus_err, bus_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                        input logic [31:0] expData, input logic expErr, input logic intPulse);
        @(negedge clk);
        bus_sel    = 1'b1;
        bus_write  = wr;
        bus_addr   = addr;
        bus_wdata  = wd;
        cordic_int = intPulse;
        sbq.push_back({expErr, expData});
        @(posedge clk);
        @(negedge clk);
        cordic_int = 1'b0;
        chk("ready_latency", {31'b0, bus_ready}, 32'd1);
        bus_sel = 1'b0;
        @(negedge clk);
        chk("ready_pulse", {31'b0, bus_ready}, 32'd0);
    endtask

    task automatic wb(input logic [31:0] val, input logic intPulse);
        @(negedge clk);
        ctrl_reg_we  = 1'b1;
        ctrl_reg_out = val;
        cordic_int   = intPulse;
        @(negedge clk);
        ctrl_reg_we = 1'b0;
        cordic_int  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_sel = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_wdata = '0;
        ctrl_reg_out = '0; ctrl_reg_we = 1'b0; cordic_int = 1'b0;
        x_result = '0; y_result = '0; z_result = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_in", ctrl_reg_in, 32'h0000_1FF0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_x_in", x_in, 32'd0);
        rst = 1'b0;

        xfer(1'b0, 5'h00, 32'h0, 32'h0001_1FF0, 1'b0, 1'b0);
        xfer(1'b0, 5'h04, 32'h0, 32'h0, 1'b0, 1'b0);

        // Load operands and start.
        xfer(1'b1, 5'h04, 32'h2000_0000, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 5'h08, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 5'h0C, 32'h1000_0000, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 5'h00, 32'h0000_1F0D, 32'h0, 1'b0, 1'b0);
        chk("x_in_load", x_in, 32'h2000_0000);
        chk("z_in_load", z_in, 32'h1000_0000);
        chk("ctrl_in_start", ctrl_reg_in, 32'h0000_1F0D);

        wb(32'h0000_1F0C, 1'b0);
        chk("ctrl_in_launched", ctrl_reg_in, 32'h0000_1F0C);
        xfer(1'b0, 5'h00, 32'h0, 32'h0000_1F0C, 1'b0, 1'b0);

        // Busy: operands locked, stop bit writable.
        xfer(1'b1, 5'h04, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
        chk("x_in_locked", x_in, 32'h2000_0000);
        xfer(1'b1, 5'h00, 32'h0000_0002, 32'h0, 1'b0, 1'b0);
        chk("ctrl_in_stop", ctrl_reg_in, 32'h0000_1F0E);
        xfer(1'b0, 5'h04, 32'h0, 32'h0, 1'b0, 1'b0);

        // Completion with interrupt.
        x_result = 32'h1111; y_result = 32'h2222; z_result = 32'h3333;
        wb(32'h0001_1F0C, 1'b1);
        chk("irq_set", {31'b0, irq}, 32'd1);
        chk("ctrl_in_done", ctrl_reg_in, 32'h0000_1F0C);
        xfer(1'b0, 5'h04, 32'h0, 32'h1111, 1'b0, 1'b0);
        xfer(1'b0, 5'h08, 32'h0, 32'h2222, 1'b0, 1'b0);
        xfer(1'b0, 5'h0C, 32'h0, 32'h3333, 1'b0, 1'b0);
        xfer(1'b0, 5'h00, 32'h0, 32'h0001_1F0C, 1'b0, 1'b0);
        xfer(1'b0, 5'h10, 32'h0, 32'h1, 1'b0, 1'b0);
        xfer(1'b1, 5'h10, 32'h1, 32'h0, 1'b0, 1'b0);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        xfer(1'b0, 5'h10, 32'h0, 32'h0, 1'b0, 1'b0);

        // Back in idle: operand writes accepted again.
        xfer(1'b1, 5'h04, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
        chk("x_in_idle", x_in, 32'h0000_0055);

        // Set beats clear.
        xfer(1'b1, 5'h10, 32'h1, 32'h0, 1'b0, 1'b1);
        chk("irq_set_wins", {31'b0, irq}, 32'd1);

        // Address errors leave state alone.
        xfer(1'b0, 5'h06, 32'h0, 32'h0, 1'b1, 1'b0);
        xfer(1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        xfer(1'b1, 5'h06, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        chk("x_in_after_err", x_in, 32'h0000_0055);

        // Start a run and reset it mid-flight.
        xfer(1'b1, 5'h00, 32'h0000_1F01, 32'h0, 1'b0, 1'b0);
        wb(32'h0000_0000, 1'b0);
        chk("ctrl_in_busy2", ctrl_reg_in, 32'h0000_1F00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl_in", ctrl_reg_in, 32'h0000_1FF0);
        chk("midrst_irq", {31'b0, irq}, 32'd0);
        chk("midrst_x_in", x_in, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 5'h00, 32'h0, 32'h0001_1FF0, 1'b0, 1'b0);
        xfer(1'b0, 5'h04, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 5'h04, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
        chk("x_in_after_rst", x_in, 32'h0000_0077);

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
